// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer:
// md_op encodings, FSM state enum and default busy-window lengths.
package md_pkg;

    localparam int unsigned MD_DATA_W = 32;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational arithmetic for the md sequencer.
// Ports:
//   a, b       in  32  latched operands (a = multiplicand/dividend, b = multiplier/divisor)
//   is_signed  in  1   1 = signed (mult/div), 0 = unsigned (multu/divu)
//   prod       out 64  full product {hi,lo}
//   quo, rem   out 32  quotient / remainder (zero when divisor is zero)
// Macro MD_DIV_EN: when undefined the divider is removed and quo/rem tie to zero.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_DATA_W-1:0]   a,
    input  logic [MD_DATA_W-1:0]   b,
    input  logic                   is_signed,
    output logic [2*MD_DATA_W-1:0] prod,
    output logic [MD_DATA_W-1:0]   quo,
    output logic [MD_DATA_W-1:0]   rem
);

    logic [2*MD_DATA_W-1:0] a_ext;
    logic [2*MD_DATA_W-1:0] b_ext;

    // One 64-bit multiplier serves both flavours: the low 64 bits of the
    // product of correctly extended operands are the same either way.
    always_comb begin
        a_ext = {{MD_DATA_W{is_signed & a[MD_DATA_W-1]}}, a};
        b_ext = {{MD_DATA_W{is_signed & b[MD_DATA_W-1]}}, b};
        prod  = a_ext * b_ext;
    end

`ifdef MD_DIV_EN
    // Divider; the signed overflow case is pinned explicitly.
    always_comb begin
        quo = '0;
        rem = '0;
        if (b == '0) begin
            quo = '0;
            rem = '0;
        end else if (is_signed) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quo = 32'h8000_0000;
                rem = '0;
            end else begin
                quo = MD_DATA_W'($signed(a) / $signed(b));
                rem = MD_DATA_W'($signed(a) % $signed(b));
            end
        end else begin
            quo = a / b;
            rem = a % b;
        end
    end
`else
    assign quo = '0;
    assign rem = '0;
`endif

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start, md_op     one-cycle operation request from E stage and its opcode
//   rs_val, rt_val   forwarded operands
//   rd_hi            selects HI (1) or LO (0) onto md_out
//   md_out           combinational read of HI/LO
//   busy             operation in progress
//   md_hold          start | busy, for the hazard unit
//   hi, lo           architectural HI/LO
// Macro MD_DIV_EN: enables div/divu; otherwise those ops are ignored.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hi,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        md_hold,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e        state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [31:0]      op_a, op_a_d;
    logic [31:0]      op_b, op_b_d;
    logic             op_sgn, op_sgn_d;
    logic [31:0]      hi_d, lo_d;

    logic [63:0]      prod;
    logic [31:0]      quo;
    logic [31:0]      rem;

    md_arith u_arith (
        .a         (op_a),
        .b         (op_b),
        .is_signed (op_sgn),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem)
    );

    // State, counter, latched operands and HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            op_a   <= op_a_d;
            op_b   <= op_b_d;
            op_sgn <= op_sgn_d;
            hi     <= hi_d;
            lo     <= lo_d;
        end
    end

    // Next-state: accept ops only in IDLE, retire result when count reaches 1
    always_comb begin
        state_d  = state;
        count_d  = count;
        op_a_d   = op_a;
        op_b_d   = op_b;
        op_sgn_d = op_sgn;
        hi_d     = hi;
        lo_d     = lo;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            op_a_d   = rs_val;
                            op_b_d   = rt_val;
                            op_sgn_d = (md_op == MD_MULT);
                            count_d  = CNT_W'(MULT_CYCLES);
                            state_d  = ST_MULT;
                        end
`ifdef MD_DIV_EN
                        MD_DIV, MD_DIVU: begin
                            op_a_d   = rs_val;
                            op_b_d   = rt_val;
                            op_sgn_d = (md_op == MD_DIV);
                            count_d  = CNT_W'(DIV_CYCLES);
                            state_d  = ST_DIV;
                        end
`endif
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MULT: begin
                count_d = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
`ifdef MD_DIV_EN
                count_d = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    // Zero divisor still burns the window but leaves HI/LO alone
                    if (op_b != '0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = ST_IDLE;
                end
`else
                count_d = '0;
                state_d = ST_IDLE;
`endif
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign md_hold = start | busy;
    assign md_out  = rd_hi ? hi : lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed vectors plus randomized ops,
// checked against a 64-bit arithmetic reference model of HI/LO.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hi;
    logic [31:0] md_out;
    logic        busy;
    logic        md_hold;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .rd_hi   (rd_hi),
        .md_out  (md_out),
        .busy    (busy),
        .md_hold (md_hold),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: new HI/LO and busy length for one accepted op from IDLE
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] nh, output logic [31:0] nl, output int n);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        nh = m_hi;
        nl = m_lo;
        n  = 0;
        case (op)
            3'd1: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; n = MULT_N; end
            3'd2: begin p = {32'h0, a} * {32'h0, b}; nh = p[63:32]; nl = p[31:0]; n = MULT_N; end
            3'd3: if (DIV_EN) begin
                n = DIV_N;
                if (b != 32'h0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
            end
            3'd4: if (DIV_EN) begin
                n = DIV_N;
                if (b != 32'h0) begin nl = a / b; nh = a % b; end
            end
            3'd5: nh = a;
            3'd6: nl = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle, scramble inputs while busy, check window and HI/LO
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nh, nl;
        int n, cnt;
        model(op, a, b, nh, nl, n);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1;
        n_cmp++;
        if (md_hold !== 1'b1) begin
            n_err++; $display("FAIL %s md_hold_start got=%b exp=1", name, md_hold);
        end
        @(posedge clk); #1;
        start = 1'b0;
        md_op = 3'($urandom_range(0, 7));
        rs_val = $urandom; rt_val = $urandom;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
            rs_val = $urandom; rt_val = $urandom;
        end
        m_hi = nh; m_lo = nl;
        n_cmp++;
        if (cnt !== n) begin
            n_err++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, cnt, n);
        end
        n_cmp++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL %s hilo got=%h/%h exp=%h/%h", name, hi, lo, m_hi, m_lo);
        end
        rd_hi = 1'b1; #1;
        n_cmp++;
        if (md_out !== m_hi) begin
            n_err++; $display("FAIL %s md_out_hi got=%h exp=%h", name, md_out, m_hi);
        end
        rd_hi = 1'b0; #1;
        n_cmp++;
        if (md_out !== m_lo) begin
            n_err++; $display("FAIL %s md_out_lo got=%h exp=%h", name, md_out, m_lo);
        end
        md_op = MD_NONE;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0; rd_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || md_hold !== 1'b0 || md_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset got hi=%h lo=%h busy=%b hold=%b out=%h exp all zero",
                     hi, lo, busy, md_hold, md_out);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        m_hi = 32'h0; m_lo = 32'h0;
    endtask

    task automatic test_directed();
        run_op("mult_neg2x3",  MD_MULT,  32'hFFFF_FFFE, 32'd3);
        run_op("multu_neg2x3", MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_op("div_m7by2",    MD_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op("divu_7by2",    MD_DIVU,  32'd7,         32'd2);
        run_op("mthi_11",      MD_MTHI,  32'h11,        32'h0);
        run_op("mtlo_22",      MD_MTLO,  32'h22,        32'h0);
        run_op("div_by_zero",  MD_DIV,   32'd5,         32'd0);
        run_op("mtlo_dead",    MD_MTLO,  32'hDEAD_BEEF, 32'h0);
        run_op("div_overflow", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("op_none",      MD_NONE,  32'h1234_5678, 32'h9);
        run_op("op_seven",     3'd7,     32'h1234_5678, 32'h9);
    endtask

    task automatic test_start_while_busy();
        logic [31:0] nh, nl;
        int n, cnt;
        model(MD_MULT, 32'd1234, 32'hFFFF_FF00, nh, nl, n);
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd1234; rt_val = 32'hFFFF_FF00;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 2) begin
                start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
            end else begin
                start = 1'b0; md_op = MD_NONE;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        m_hi = nh; m_lo = nl;
        n_cmp++;
        if (cnt !== MULT_N) begin
            n_err++; $display("FAIL busy_start busy_cycles got=%0d exp=%0d", cnt, MULT_N);
        end
        n_cmp++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL busy_start hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL busy_start trailing_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int cnt;
        logic [2:0] op;
        op = DIV_EN ? MD_DIV : MD_MULT;
        start = 1'b1; md_op = op; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        cnt = 1;
        while (cnt < 3) begin
            @(posedge clk); #1;
            cnt++;
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b exp 0/0/0", hi, lo, busy);
        end
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset_mult", MD_MULT, 32'd2, 32'd3);
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op("random", op, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
